// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands a UART transmitter to one byte-stream requester per packet.
// Optional macro UART_ARB_TIMEOUT_EN adds forced release of an owner that stalls mid-packet.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               tx_valid_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_ready_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] GRANT0 = N_REQ'(1);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e           state_q;
    logic [IW-1:0]    owner_q;
    logic [IW-1:0]    last_owner_q;
    logic [N_REQ-1:0] grant_q;

    logic             owner_found;
    logic [IW-1:0]    owner_d;
    logic [IW-1:0]    cand;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       owner_data;
    logic             handshake;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]      idle_cnt_q;
    logic             timeout_q;
`endif

    // Walk offsets from farthest to nearest so the requester closest after last_owner wins.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        owner_found = 1'b0;
        owner_d     = last_owner_q;
        cand        = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IW'((int'(last_owner_q) + i) % N_REQ);
            if (req_valid_i[cand]) begin
                owner_found = 1'b1;
                owner_d     = cand;
            end
        end
    end

    assign owner_valid = req_valid_i[owner_q];
    assign owner_last  = req_last_i[owner_q];
    assign owner_data  = req_data_i[{owner_q, 3'b000} +: 8];

    assign tx_valid_o  = (state_q == OWN) & owner_valid;
    assign tx_data_o   = (state_q == OWN) ? owner_data : 8'h00;
    assign handshake   = tx_valid_o & tx_ready_i;
    assign req_ready_o = grant_q & {N_REQ{tx_ready_i}};
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == OWN);

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IW'(N_REQ - 1);
            grant_q      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (owner_found) begin
                        state_q <= OWN;
                        owner_q <= owner_d;
                        grant_q <= GRANT0 << owner_d;
`ifdef UART_ARB_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end
                OWN: begin
                    if (handshake && owner_last) begin
                        state_q      <= IDLE;
                        last_owner_q <= owner_q;
                        grant_q      <= '0;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (!owner_valid) begin
                        // Release on the edge where the count of silent owner cycles reaches TIMEOUT.
                        if (idle_cnt_q == 16'(TIMEOUT - 1)) begin
                            state_q      <= IDLE;
                            last_owner_q <= owner_q;
                            grant_q      <= '0;
                            idle_cnt_q   <= '0;
                            timeout_q    <= 1'b1;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 16'd1;
                        end
                    end else if (handshake) begin
                        idle_cnt_q <= '0;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a packet-level reference model.
// Build with UART_ARB_TIMEOUT_EN defined to also exercise forced release with TIMEOUT=8.
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic [N-1:0]   req_valid_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           tx_valid_o;
    logic [7:0]     tx_data_o;
    logic           tx_ready_i;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic           timeout_o;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 when none), last owner, silent-cycle count, pending pulse.
    int m_owner;
    int m_last;
    int m_idle;
    bit m_to;

    logic [N-1:0] seen_grant;
    logic [N-1:0] seen_ready;
    logic [7:0]   seen_data;
    logic         seen_hs;
    logic         seen_busy;
    logic         seen_to;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] vec, input int idx);
        return ((vec >> idx) & N'(1)) != '0;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_idle  = 0;
        m_to    = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ev;
        logic [7:0]   ed;
        eg = '0;
        ev = 1'b0;
        ed = 8'h00;
        if (m_owner >= 0) begin
            eg = N'(1) << m_owner;
            ev = bit_of(req_valid_i, m_owner);
            ed = 8'(req_data_i >> (8 * m_owner));
        end
        er = tx_ready_i ? eg : '0;
        check({tag, "_grant"}, 32'(grant_o),     32'(eg));
        check({tag, "_busy"},  32'(busy_o),      32'(m_owner >= 0));
        check({tag, "_txv"},   32'(tx_valid_o),  32'(ev));
        check({tag, "_txd"},   32'(tx_data_o),   32'(ed));
        check({tag, "_rdy"},   32'(req_ready_o), 32'(er));
        check({tag, "_tmo"},   32'(timeout_o),   32'(m_to));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_advance();
        bit v;
        bit hs;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (bit_of(req_valid_i, c)) begin
                    m_owner = c;
                    m_idle  = 0;
                    break;
                end
            end
        end else begin
            v  = bit_of(req_valid_i, m_owner);
            hs = v && tx_ready_i;
            if (hs && bit_of(req_last_i, m_owner)) begin
                m_last  = m_owner;
                m_owner = -1;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (!v) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_idle  = 0;
                    m_to    = 1'b1;
                end
            end else if (hs) begin
                m_idle = 0;
            end
`endif
        end
    endtask

    // Called at a falling edge: apply inputs, compare, then step model and DUT one clock.
    task automatic cycle(input string tag, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [8*N-1:0] d, input logic r);
        req_valid_i = v;
        req_last_i  = l;
        req_data_i  = d;
        tx_ready_i  = r;
        #1;
        seen_grant = grant_o;
        seen_ready = req_ready_o;
        seen_data  = tx_data_o;
        seen_hs    = tx_valid_o & tx_ready_i;
        seen_busy  = busy_o;
        seen_to    = timeout_o;
        check_outputs(tag);
        model_advance();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rstn_i      = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        tx_ready_i  = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    initial begin
        logic [7:0]   b31 [5];
        logic [N-1:0] g32 [10];
        logic [N-1:0] rv;
        logic [N-1:0] rl;

        rstn_i      = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        tx_ready_i  = 1'b0;
        @(negedge clk_i);

        // Three-byte packet from requester 0 with an always-ready sink.
        do_reset();
        b31 = '{8'h41, 8'h41, 8'h42, 8'h43, 8'h00};
        for (int j = 0; j < 5; j++) begin
            cycle("pkt3", (j < 4) ? 4'b0001 : 4'b0000, (j == 3) ? 4'b0001 : 4'b0000,
                  {24'h0, b31[j]}, 1'b1);
            check("pkt3_grant", 32'(seen_grant), (j >= 1 && j <= 3) ? 32'd1 : 32'd0);
            check("pkt3_hs", 32'(seen_hs), 32'(j >= 1 && j <= 3));
            if (j >= 1 && j <= 3) check("pkt3_byte", 32'(seen_data), 32'(b31[j]));
        end

        // All four requesters continuously valid with single-byte packets.
        do_reset();
        g32 = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        for (int j = 0; j < 10; j++) begin
            cycle("rr", 4'b1111, 4'b1111, 32'hD3C2B1A0, 1'b1);
            check("rr_order", 32'(seen_grant), 32'(g32[j]));
        end

        // Owner 1 goes silent mid-packet while requester 2 waits.
        do_reset();
        cycle("hold", 4'b0010, 4'b0000, 32'h0000_1100, 1'b1);
        cycle("hold", 4'b0010, 4'b0000, 32'h0000_1100, 1'b1);
        for (int j = 0; j < 5; j++) begin
            cycle("hold", 4'b0100, 4'b0100, 32'h0022_0000, 1'b1);
            check("hold_grant", 32'(seen_grant), 32'h2);
            check("hold_rdy2", 32'(seen_ready[2]), 32'd0);
        end
        cycle("hold", 4'b0110, 4'b0110, 32'h0022_1100, 1'b1);
        cycle("hold", 4'b0100, 4'b0100, 32'h0022_0000, 1'b1);
        cycle("hold", 4'b0100, 4'b0100, 32'h0022_0000, 1'b1);
        check("hold_next", 32'(seen_grant), 32'h4);

        // Sink stalls for 20 cycles while 0x55 is presented.
        do_reset();
        cycle("stall", 4'b0001, 4'b0001, 32'h55, 1'b0);
        for (int j = 0; j < 20; j++) begin
            cycle("stall", 4'b0001, 4'b0001, 32'h55, 1'b0);
            check("stall_data", 32'(seen_data), 32'h55);
            check("stall_rdy", 32'(seen_ready), 32'd0);
            check("stall_tmo", 32'(seen_to), 32'd0);
        end
        cycle("stall", 4'b0001, 4'b0001, 32'h55, 1'b1);
        check("stall_hs", 32'(seen_hs), 32'd1);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner 0 stops mid-packet; requester 1 should follow after the forced release.
        do_reset();
        cycle("tmo", 4'b0001, 4'b0000, 32'h0000_0077, 1'b1);
        cycle("tmo", 4'b0001, 4'b0000, 32'h0000_0077, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            cycle("tmo", 4'b0010, 4'b0000, 32'h0000_8800, 1'b1);
            check("tmo_pulse", 32'(seen_to), 32'(j == 9));
            check("tmo_grant", 32'(seen_grant), (j <= 8) ? 32'h1 : ((j == 9) ? 32'h0 : 32'h2));
        end
`endif

        // Asynchronous reset while the owner is on byte 2 of 4.
        do_reset();
        cycle("rstmid", 4'b0001, 4'b0000, 32'hA1, 1'b1);
        cycle("rstmid", 4'b0001, 4'b0000, 32'hA1, 1'b1);
        req_valid_i = 4'b0001;
        req_data_i  = 32'hA2;
        tx_ready_i  = 1'b1;
        rstn_i      = 1'b0;
        #1;
        model_reset();
        check_outputs("rstmid_async");
        check("rstmid_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        cycle("rstmid", 4'b0011, 4'b0000, 32'h0000_B2A3, 1'b1);
        cycle("rstmid", 4'b0011, 4'b0000, 32'h0000_B2A3, 1'b1);
        check("rstmid_first", 32'(seen_grant), 32'h1);

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rv = '0;
            rl = '0;
            for (int k = 0; k < N; k++) begin
                rv = (rv << 1) | N'($urandom_range(99) < 60);
                rl = (rl << 1) | N'($urandom_range(99) < 30);
            end
            cycle("rand", rv, rl, 32'($urandom()), 1'($urandom_range(99) < 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
